// File: rtl/xor_frame_checksum.sv
// Streaming XOR checksum engine: folds a valid/ready frame of WIDTH-bit words
// into one XOR word plus a saturating beat count. Optional XOR_CKSUM_CHECK_EN adds exp_cksum/out_err.
module xor_frame_checksum #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef XOR_CKSUM_CHECK_EN
  input  logic [WIDTH-1:0] exp_cksum,
  output logic             out_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_cksum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_sum;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             ovf, cnt_full, beat;

  // In HOLD a new beat is only taken when the held result leaves the same cycle.
  assign in_ready  = (state == ACCUM) || out_ready;
  assign out_valid = (state == HOLD);
  assign beat      = in_valid && in_ready;

  assign acc_sum  = acc ^ in_data;
  assign cnt_full = (cnt == CNT_W'(MAX_WORDS));
  assign cnt_inc  = cnt_full ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registered state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ACCUM: if (beat && in_last) state_nxt = HOLD;
      HOLD:  if (out_ready && !(beat && in_last)) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // acc/cnt are zero whenever a frame starts, so a beat taken in HOLD opens the
  // next frame without special casing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_cksum    <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
`ifdef XOR_CKSUM_CHECK_EN
      out_err      <= 1'b0;
`endif
    end else if (beat) begin
      if (in_last) begin
        acc          <= '0;
        cnt          <= '0;
        ovf          <= 1'b0;
        out_cksum    <= acc_sum;
        out_count    <= cnt_inc;
        out_overflow <= ovf || cnt_full;
`ifdef XOR_CKSUM_CHECK_EN
        out_err      <= (acc_sum != exp_cksum);
`endif
      end else begin
        acc <= acc_sum;
        cnt <= cnt_inc;
        // A beat arriving with cnt already full is beat MAX_WORDS+1 or later.
        ovf <= ovf || cnt_full;
      end
    end
  end

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Self-checking bench for xor_frame_checksum: directed cases plus randomized
// traffic against a frame-level reference model (word queue -> xor/length).
module tb_xor_frame_checksum;
  localparam int W   = 8;
  localparam int MAX = 16;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_last, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid, out_overflow;
  logic [W-1:0]  out_cksum;
  logic [CW-1:0] out_count;
`ifdef XOR_CKSUM_CHECK_EN
  logic [W-1:0]  exp_cksum;
  logic          out_err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xor_frame_checksum #(.WIDTH(W), .MAX_WORDS(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
`ifdef XOR_CKSUM_CHECK_EN
    .exp_cksum(exp_cksum), .out_err(out_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_cksum(out_cksum),
    .out_count(out_count), .out_overflow(out_overflow)
  );

  typedef struct {
    logic [W-1:0]  cksum;
    logic [CW-1:0] count;
    logic          ovf;
    logic          err;
  } result_t;

  // Frame-level model: checksum is the XOR of all words, count is length clipped.
  function automatic result_t model_frame(input logic [W-1:0] words[$], input logic [W-1:0] expv);
    result_t r;
    r.cksum = '0;
    foreach (words[i]) r.cksum = r.cksum ^ words[i];
    r.count = (words.size() > MAX) ? CW'(MAX) : CW'(words.size());
    r.ovf   = (words.size() > MAX);
    r.err   = (r.cksum != expv);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
`ifdef XOR_CKSUM_CHECK_EN
    exp_cksum = '0;
`endif
    step();
    step();
    checks++;
    if ({in_ready, out_valid, out_cksum, out_count, out_overflow} !== {1'b1, 1'b0, 8'h00, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b ck=%h cnt=%0d ovf=%b, expected rdy=1 vld=0 ck=00 cnt=0 ovf=0",
               in_ready, out_valid, out_cksum, out_count, out_overflow);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_frame();
    drive(1'b1, 8'hA5, 1'b0, 1'b0); step();
    drive(1'b1, 8'h0F, 1'b0, 1'b0); step();
    drive(1'b1, 8'hF0, 1'b1, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_cksum, out_count, out_overflow} !== {1'b1, 8'h5A, 5'd3, 1'b0}) begin
      errors++;
      $display("FAIL basic_frame: vld=%b ck=%h cnt=%0d ovf=%b, expected vld=1 ck=5a cnt=3 ovf=0",
               out_valid, out_cksum, out_count, out_overflow);
    end
  endtask

  task automatic test_backpressure();
    // Offered 3C/last must be ignored while the result is held.
    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({in_ready, out_valid, out_cksum, out_count, out_overflow} !== {1'b0, 1'b1, 8'h5A, 5'd3, 1'b0}) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: rdy=%b vld=%b ck=%h cnt=%0d ovf=%b, expected rdy=0 vld=1 ck=5a cnt=3 ovf=0",
                 i, in_ready, out_valid, out_cksum, out_count, out_overflow);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release_ready: got %b expected 1", in_ready);
    end
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_cksum, out_count, out_overflow} !== {1'b1, 8'h3C, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL same_cycle_frame: vld=%b ck=%h cnt=%0d ovf=%b, expected vld=1 ck=3c cnt=1 ovf=0",
               out_valid, out_cksum, out_count, out_overflow);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL consume_result: out_valid=%b expected 0", out_valid);
    end
  endtask

  // Frames of 18, 16, 17 ones sent back to back with out_ready held high.
  task automatic test_saturation();
    int lens[3] = '{18, 16, 17};
    logic [W-1:0]  exp_ck[3]  = '{8'h00, 8'h00, 8'h01};
    logic [CW-1:0] exp_cnt[3] = '{5'd16, 5'd16, 5'd16};
    logic          exp_ovf[3] = '{1'b1, 1'b0, 1'b1};
    for (int f = 0; f < 3; f++) begin
      for (int b = 1; b <= lens[f]; b++) begin
        drive(1'b1, 8'h01, (b == lens[f]), 1'b1);
        step();
      end
      checks++;
      if ({out_valid, out_cksum, out_count, out_overflow} !== {1'b1, exp_ck[f], exp_cnt[f], exp_ovf[f]}) begin
        errors++;
        $display("FAIL saturation len=%0d: vld=%b ck=%h cnt=%0d ovf=%b, expected vld=1 ck=%h cnt=%0d ovf=%b",
                 lens[f], out_valid, out_cksum, out_count, out_overflow, exp_ck[f], exp_cnt[f], exp_ovf[f]);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
  endtask

  task automatic test_reset_mid_frame();
    drive(1'b1, 8'hFF, 1'b0, 1'b1); step();
    drive(1'b1, 8'h11, 1'b0, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive(1'b1, 8'h22, 1'b1, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_cksum, out_count, out_overflow} !== {1'b1, 8'h22, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_frame: vld=%b ck=%h cnt=%0d ovf=%b, expected vld=1 ck=22 cnt=1 ovf=0",
               out_valid, out_cksum, out_count, out_overflow);
    end
    out_ready = 1'b1;
    step();
  endtask

`ifdef XOR_CKSUM_CHECK_EN
  task automatic test_check_en();
    logic [W-1:0] expv[2] = '{8'h26, 8'h27};
    logic         exp_e[2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 8'h12, 1'b0, 1'b1); exp_cksum = 8'hEE; step();
      drive(1'b1, 8'h34, 1'b1, 1'b1); exp_cksum = expv[k]; step();
      drive(1'b0, 8'h00, 1'b0, 1'b1); exp_cksum = 8'h00;
      checks++;
      if ({out_valid, out_cksum, out_err} !== {1'b1, 8'h26, exp_e[k]}) begin
        errors++;
        $display("FAIL check_en exp=%h: vld=%b ck=%h err=%b, expected vld=1 ck=26 err=%b",
                 expv[k], out_valid, out_cksum, out_err, exp_e[k]);
      end
      step();
    end
  endtask
`endif

  // Random traffic; b2b keeps in_valid and out_ready high for full throughput.
  task automatic test_random(input int cycles, input bit b2b, input string name);
    logic [W-1:0] words[$];
    result_t      pend[$];
    result_t      r;
    int           remaining = 0;
    logic         exp_rdy;
    logic [W-1:0] expv = '0;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (remaining == 0)
        remaining = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 20) : $urandom_range(1, 6);
      in_valid  = b2b ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      in_last   = in_valid ? (remaining == 1) : 1'($urandom_range(0, 1));
      out_ready = b2b ? 1'b1 : ($urandom_range(0, 2) != 0);
      expv      = W'($urandom);
`ifdef XOR_CKSUM_CHECK_EN
      exp_cksum = expv;
`endif
      @(negedge clk);
      exp_rdy = (pend.size() == 0) || out_ready;
      checks++;
      if ({out_valid, in_ready} !== {(pend.size() != 0), exp_rdy}) begin
        errors++;
        $display("FAIL %s handshake cycle %0d: vld=%b rdy=%b, expected vld=%b rdy=%b",
                 name, c, out_valid, in_ready, (pend.size() != 0), exp_rdy);
      end
      if (pend.size() != 0) begin
        checks++;
        if ({out_cksum, out_count, out_overflow} !== {pend[0].cksum, pend[0].count, pend[0].ovf}) begin
          errors++;
          $display("FAIL %s result cycle %0d: ck=%h cnt=%0d ovf=%b, expected ck=%h cnt=%0d ovf=%b",
                   name, c, out_cksum, out_count, out_overflow, pend[0].cksum, pend[0].count, pend[0].ovf);
        end
`ifdef XOR_CKSUM_CHECK_EN
        checks++;
        if (out_err !== pend[0].err) begin
          errors++;
          $display("FAIL %s out_err cycle %0d: got %b expected %b", name, c, out_err, pend[0].err);
        end
`endif
        if (out_ready) void'(pend.pop_front());
      end
      if (in_valid && exp_rdy) begin
        words.push_back(in_data);
        remaining--;
        if (in_last) begin
          r = model_frame(words, expv);
          pend.push_back(r);
          words.delete();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_saturation();
    test_reset_mid_frame();
`ifdef XOR_CKSUM_CHECK_EN
    test_check_en();
`endif
    test_random(1500, 1'b0, "random");
    test_random(600, 1'b1, "back_to_back");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
